// File: rtl/mic_pkg.sv
// Shared types and constants for the PDM microphone clock generator.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        STOP   = 2'd3
    } mic_state_t;

    localparam int MIN_RATIO = 4;

    // Settle counter must hold values up to SETTLE_CYC.
    function automatic int settle_w(input int settle_cyc);
        return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
    endfunction

endpackage

// File: rtl/mic_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module mic_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mic_clk_gen.sv
// PDM microphone clock generator with programmable divide ratio and
// stereo data capture (left on the high phase, right on the low phase).
module mic_clk_gen
    import mic_pkg::*;
#(
    parameter int DIV_W      = 10,
    parameter int DEF_RATIO  = 250,
    parameter int NUM_DATA   = 4,
    parameter int SETTLE_CYC = 1024
) (
    input  logic                clkin1,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                enable,
    input  logic [DIV_W-1:0]    ratio,
    input  logic                ratio_load,
    input  logic [NUM_DATA-1:0] pdm_din,
    output logic                mic_clk,
    output logic [NUM_DATA-1:0] pdm_l,
    output logic [NUM_DATA-1:0] pdm_r,
    output logic                pdm_valid,
    output logic                running,
    output logic                ratio_err,
    output mic_state_t          dbg_state
);

    localparam int                 SW          = settle_w(SETTLE_CYC);
    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0]      SETTLE_ONE  = SW'(1);
    localparam logic [DIV_W-1:0]   MIN_R       = DIV_W'(MIN_RATIO);
    localparam logic [DIV_W-1:0]   ONE         = DIV_W'(1);
    localparam logic [DIV_W-1:0]   RATIO_RST   = DIV_W'(DEF_RATIO);

    mic_state_t          state, state_nx;
    logic                lock_s;
    logic [SW-1:0]       settle_cnt;
    logic [DIV_W-1:0]    cnt, cnt_nx;
    logic [DIV_W-1:0]    ratio_act, ratio_act_nx;
    logic [DIV_W-1:0]    ratio_pend, ratio_pend_nx;
    logic [DIV_W-1:0]    half, half_nx;
    logic                pend_flag, pend_flag_nx;
    logic [NUM_DATA-1:0] din_q, left_sh;
    logic                primed;
    logic                active, active_nx, wrap, settle_done;
    logic                load_ok, load_bad, apply, capture, emit;
    logic                mic_clk_nx;

    mic_sync2 u_lock_sync (
        .clk (clkin1),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign active      = (state == RUN) || (state == STOP);
    assign half        = ratio_act >> 1;
    assign wrap        = active && (cnt == ratio_act - ONE);
    assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign load_ok     = ratio_load && (ratio >= MIN_R);
    assign load_bad    = ratio_load && (ratio < MIN_R);
    // Left data is taken just before the falling edge; a completed period is
    // reported at the next cnt==0, which is also the IDLE cycle after a stop.
    assign capture     = active && lock_s && (cnt == half);
    assign emit        = primed && lock_s && (cnt == '0);

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (lock_s && enable) state_nx = SETTLE;
            end
            SETTLE: begin
                if (!lock_s)          state_nx = IDLE;
                else if (settle_done) state_nx = RUN;
            end
            RUN: begin
                if (!lock_s)          state_nx = IDLE;
                else if (!enable)     state_nx = wrap ? IDLE : STOP;
            end
            STOP: begin
                if (!lock_s)          state_nx = IDLE;
                else if (enable)      state_nx = RUN;
                else if (wrap)        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        active_nx  = (state_nx == RUN) || (state_nx == STOP);
        mic_clk_nx = active_nx && (cnt_nx < half_nx);
        running    = active;
        dbg_state  = state;
    end

    // A pending ratio (or one loaded this cycle) takes effect at a period
    // boundary, or straight away while no clock is being produced.
    always_comb begin
        apply         = (load_ok || pend_flag) &&
                        ((state == IDLE) || (state == SETTLE) || wrap);
        ratio_pend_nx = load_ok ? ratio : ratio_pend;
        pend_flag_nx  = (load_ok || pend_flag) && !apply;
        ratio_act_nx  = apply ? ratio_pend_nx : ratio_act;
        half_nx       = ratio_act_nx >> 1;
        cnt_nx        = '0;
        if (active && active_nx && !wrap) cnt_nx = cnt + ONE;
    end

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            cnt        <= '0;
            ratio_act  <= RATIO_RST;
            ratio_pend <= RATIO_RST;
            pend_flag  <= 1'b0;
            ratio_err  <= 1'b0;
            mic_clk    <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + SETTLE_ONE : '0;
            cnt        <= cnt_nx;
            ratio_act  <= ratio_act_nx;
            ratio_pend <= ratio_pend_nx;
            pend_flag  <= pend_flag_nx;
            mic_clk    <= mic_clk_nx;
            if (load_bad) ratio_err <= 1'b1;
        end
    end

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            din_q     <= '0;
            left_sh   <= '0;
            primed    <= 1'b0;
            pdm_l     <= '0;
            pdm_r     <= '0;
            pdm_valid <= 1'b0;
        end else begin
            din_q     <= pdm_din;
            pdm_valid <= emit;
            if (capture) left_sh <= din_q;
            if (emit) begin
                pdm_l <= left_sh;
                pdm_r <= din_q;
            end
            // Losing lock discards a half-captured period.
            if (!lock_s)      primed <= 1'b0;
            else if (emit)    primed <= 1'b0;
            else if (capture) primed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mic_clk_gen.sv
// Self-checking bench for mic_clk_gen: randomized PDM data per phase, periods
// and capture expectations derived from the divide ratio with plain arithmetic.
module tb_mic_clk_gen;
    import mic_pkg::*;

    localparam int DIV_W      = 10;
    localparam int DEF_RATIO  = 8;
    localparam int NUM_DATA   = 4;
    localparam int SETTLE_CYC = 16;
    localparam int SYNC_CYC   = 2;
    localparam int DMAX       = (1 << NUM_DATA) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                pll_lock;
    logic                enable;
    logic [DIV_W-1:0]    ratio;
    logic                ratio_load;
    logic [NUM_DATA-1:0] pdm_din;
    logic                mic_clk;
    logic [NUM_DATA-1:0] pdm_l;
    logic [NUM_DATA-1:0] pdm_r;
    logic                pdm_valid;
    logic                running;
    logic                ratio_err;
    mic_state_t          dbg_state;

    int checks = 0;
    int passes = 0;
    logic [2*NUM_DATA-1:0] exp_q[$];
    logic [NUM_DATA-1:0]   next_hi, next_lo;

    mic_clk_gen #(
        .DIV_W(DIV_W), .DEF_RATIO(DEF_RATIO), .NUM_DATA(NUM_DATA), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clkin1(clk), .rst(rst), .pll_lock(pll_lock), .enable(enable),
        .ratio(ratio), .ratio_load(ratio_load), .pdm_din(pdm_din),
        .mic_clk(mic_clk), .pdm_l(pdm_l), .pdm_r(pdm_r), .pdm_valid(pdm_valid),
        .running(running), .ratio_err(ratio_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Cycles with no clock output; the clock must start on the cycle after.
    task automatic settle_phase(input int n);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            ratio_load = 1'b0;
            checks++; if (mic_clk !== 1'b0) $display("FAIL settle_mic_clk i=%0d got %b want 0", i, mic_clk); else passes++;
            checks++; if (running !== 1'b0) $display("FAIL settle_running i=%0d got %b want 0", i, running); else passes++;
            checks++; if (pdm_valid !== 1'b0) $display("FAIL settle_valid i=%0d got %b want 0", i, pdm_valid); else passes++;
            pdm_din = NUM_DATA'($urandom_range(DMAX, 0));
        end
    endtask

    // One full mic_clk period of ratio r, with optional loads and enable edges.
    task automatic run_period(input int r, input int l1_at, input int l1_v, input int l2_at,
                              input int l2_v, input int drop_at, input int raise_at);
        logic [NUM_DATA-1:0]   hi, lo;
        logic [2*NUM_DATA-1:0] exp;
        logic                  exp_valid;
        hi = next_hi;
        lo = next_lo;
        next_hi = NUM_DATA'($urandom_range(DMAX, 0));
        next_lo = NUM_DATA'($urandom_range(DMAX, 0));
        for (int p = 0; p < r; p++) begin
            @(negedge clk);
            checks++; if (mic_clk !== (p < r / 2)) $display("FAIL period_mic_clk r=%0d p=%0d got %b want %b", r, p, mic_clk, (p < r / 2)); else passes++;
            checks++; if (running !== 1'b1) $display("FAIL period_running r=%0d p=%0d got %b want 1", r, p, running); else passes++;
            exp_valid = (p == 1) && (exp_q.size() > 0);
            checks++; if (pdm_valid !== exp_valid) $display("FAIL period_valid r=%0d p=%0d got %b want %b", r, p, pdm_valid, exp_valid); else passes++;
            if (exp_valid) begin
                exp = exp_q.pop_front();
                checks++; if ({pdm_l, pdm_r} !== exp) $display("FAIL period_data r=%0d got l=%h r=%h want l=%h r=%h", r, pdm_l, pdm_r, exp[2*NUM_DATA-1:NUM_DATA], exp[NUM_DATA-1:0]); else passes++;
            end
            pdm_din    = (p < r / 2) ? hi : lo;
            ratio_load = 1'b0;
            if (p == l1_at) begin ratio_load = 1'b1; ratio = DIV_W'(l1_v); end
            if (p == l2_at) begin ratio_load = 1'b1; ratio = DIV_W'(l2_v); end
            if (p == drop_at)  enable = 1'b0;
            if (p == raise_at) enable = 1'b1;
        end
        exp_q.push_back({hi, lo});
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock = 1'b0; enable = 1'b0; ratio = '0; ratio_load = 1'b0; pdm_din = '0;
        repeat (3) @(negedge clk);
        checks++; if (mic_clk !== 1'b0) $display("FAIL reset_mic_clk got %b want 0", mic_clk); else passes++;
        checks++; if ({pdm_l, pdm_r} !== '0) $display("FAIL reset_data got %h want 0", {pdm_l, pdm_r}); else passes++;
        checks++; if (pdm_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", pdm_valid); else passes++;
        checks++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else passes++;
        checks++; if (ratio_err !== 1'b0) $display("FAIL reset_ratio_err got %b want 0", ratio_err); else passes++;
        checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dbg_state); else passes++;
    endtask

    task automatic test_startup();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        enable   = 1'b1;
        settle_phase(SYNC_CYC + 1 + SETTLE_CYC);
    endtask

    task automatic test_data_capture();
        for (int i = 0; i < 2; i++) begin
            next_hi = 4'hA;
            next_lo = 4'h5;
            run_period(8, -1, 0, -1, 0, -1, -1);
        end
        run_period(8, -1, 0, -1, 0, -1, -1);
    endtask

    task automatic test_ratio_change();
        run_period(8, 3, 10, -1, 0, -1, -1);
        run_period(10, -1, 0, -1, 0, -1, -1);
        checks++; if (ratio_err !== 1'b0) $display("FAIL ratio_err_clear got %b want 0", ratio_err); else passes++;
        run_period(10, 4, 3, -1, 0, -1, -1);
        checks++; if (ratio_err !== 1'b1) $display("FAIL ratio_err_set got %b want 1", ratio_err); else passes++;
        run_period(10, 6, 8, -1, 0, -1, -1);
    endtask

    task automatic test_graceful_stop();
        logic [2*NUM_DATA-1:0] exp;
        run_period(8, -1, 0, -1, 0, 2, -1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ratio_load = 1'b0;
            checks++; if (mic_clk !== 1'b0) $display("FAIL stop_mic_clk i=%0d got %b want 0", i, mic_clk); else passes++;
            checks++; if (running !== 1'b0) $display("FAIL stop_running i=%0d got %b want 0", i, running); else passes++;
            checks++; if (pdm_valid !== (i == 1)) $display("FAIL stop_valid i=%0d got %b want %b", i, pdm_valid, (i == 1)); else passes++;
            if (i == 1) begin
                exp = exp_q.pop_front();
                checks++; if ({pdm_l, pdm_r} !== exp) $display("FAIL stop_data got %h want %h", {pdm_l, pdm_r}, exp); else passes++;
            end
        end
        checks++; if (dbg_state !== IDLE) $display("FAIL stop_state got %0d want IDLE", dbg_state); else passes++;
    endtask

    task automatic test_restart();
        @(negedge clk);
        enable = 1'b1;
        settle_phase(1 + SETTLE_CYC);
        run_period(8, -1, 0, -1, 0, -1, -1);
        run_period(8, -1, 0, -1, 0, -1, -1);
    endtask

    task automatic test_lock_loss();
        logic [2*NUM_DATA-1:0] exp;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            checks++; if (mic_clk !== (p < 4)) $display("FAIL lock_pre_mic_clk p=%0d got %b want %b", p, mic_clk, (p < 4)); else passes++;
            if (p == 1) begin
                exp = exp_q.pop_front();
                checks++; if (pdm_valid !== 1'b1 || {pdm_l, pdm_r} !== exp) $display("FAIL lock_pre_data got v=%b %h want v=1 %h", pdm_valid, {pdm_l, pdm_r}, exp); else passes++;
            end
            if (p == 2) pll_lock = 1'b0;
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++; if (mic_clk !== 1'b0) $display("FAIL lock_mic_clk i=%0d got %b want 0", i, mic_clk); else passes++;
            checks++; if (running !== 1'b0) $display("FAIL lock_running i=%0d got %b want 0", i, running); else passes++;
            checks++; if (pdm_valid !== 1'b0) $display("FAIL lock_valid i=%0d got %b want 0", i, pdm_valid); else passes++;
        end
        @(negedge clk);
        pll_lock = 1'b1;
        settle_phase(SYNC_CYC + 1 + SETTLE_CYC);
        run_period(8, -1, 0, -1, 0, -1, -1);
        run_period(8, -1, 0, -1, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_period(8, 2, 12, 5, 6, -1, -1);
        run_period(6, 5, 9, -1, 0, -1, -1);
        run_period(9, -1, 0, -1, 0, 1, 3);
        run_period(9, -1, 0, -1, 0, -1, -1);
    endtask

    task automatic test_async_reset();
        logic [2*NUM_DATA-1:0] exp;
        @(negedge clk);
        checks++; if (mic_clk !== 1'b1) $display("FAIL areset_pre_mic_clk got %b want 1", mic_clk); else passes++;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (pdm_valid !== 1'b1 || {pdm_l, pdm_r} !== exp) $display("FAIL areset_pre_data got v=%b %h want v=1 %h", pdm_valid, {pdm_l, pdm_r}, exp); else passes++;
        checks++; if (ratio_err !== 1'b1) $display("FAIL areset_pre_err got %b want 1", ratio_err); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (mic_clk !== 1'b0) $display("FAIL areset_mic_clk got %b want 0", mic_clk); else passes++;
        checks++; if ({pdm_l, pdm_r, pdm_valid} !== '0) $display("FAIL areset_data got %h want 0", {pdm_l, pdm_r, pdm_valid}); else passes++;
        checks++; if (running !== 1'b0) $display("FAIL areset_running got %b want 0", running); else passes++;
        checks++; if (ratio_err !== 1'b0) $display("FAIL areset_ratio_err got %b want 0", ratio_err); else passes++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        settle_phase(SYNC_CYC + 1 + SETTLE_CYC);
        run_period(DEF_RATIO, -1, 0, -1, 0, -1, -1);
        run_period(DEF_RATIO, -1, 0, -1, 0, -1, -1);
        checks++; if (ratio_err !== 1'b0) $display("FAIL areset_post_err got %b want 0", ratio_err); else passes++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_data_capture();
        test_ratio_change();
        test_graceful_stop();
        test_restart();
        test_lock_loss();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
